// File: rtl/test_harness_pkg.sv
// Shared types, widths and golden-value helper for the self-checking series harness.
package test_harness_pkg;

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned TERM_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRun,
    StCheck,
    StPass,
    StFail
  } th_state_t;

  // Closed-form arithmetic-series sum 1 + 2 + ... + n.
  function automatic logic [ACC_W-1:0] series_gold(input int unsigned n);
    logic [63:0] prod;
    prod = 64'(n) * (64'(n) + 64'd1);
    return prod[ACC_W:1];
  endfunction

endpackage

// File: rtl/test_harness_if.sv
// Control/result bundle between the harness FSM (master) and the series accumulator (slave).
interface test_harness_if;
  import test_harness_pkg::*;

  logic             clear;
  logic             enable;
  logic [ACC_W-1:0] acc;
  logic             last;

  modport master  (output clear, output enable, input acc, input last);
  modport slave   (input clear, input enable, output acc, output last);
  modport monitor (input clear, input enable, input acc, input last);

endinterface

// File: rtl/harness_accum.sv
// Series accumulator and term counter; TEST_HARNESS_INJECT_ERR_EN corrupts the final-term addend.
module harness_accum
  import test_harness_pkg::*;
#(
  parameter int unsigned NUM_TERMS = 100
) (
  input logic            clk_i,
  input logic            rst_ni,
  test_harness_if.slave  acc_bus
);

  logic [ACC_W-1:0]  acc_q, acc_d, addend;
  logic [TERM_W-1:0] term_q, term_d;
  logic              last;

  assign last = (term_q == TERM_W'(NUM_TERMS));

`ifdef TEST_HARNESS_INJECT_ERR_EN
  // Final term contributes term+1, so the golden comparison must fail.
  assign addend = ACC_W'(term_q) + ACC_W'(last);
`else
  assign addend = ACC_W'(term_q);
`endif

  always_comb begin
    acc_d  = acc_q;
    term_d = term_q;
    if (acc_bus.clear) begin
      acc_d  = '0;
      term_d = TERM_W'(1);
    end else if (acc_bus.enable) begin
      acc_d  = acc_q + addend;
      term_d = term_q + TERM_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      term_q <= '0;
    end else begin
      acc_q  <= acc_d;
      term_q <= term_d;
    end
  end

  assign acc_bus.acc  = acc_q;
  assign acc_bus.last = last;

endmodule

// File: rtl/test_harness.sv
// Self-checking harness: delay, accumulate N series terms, compare to N*(N+1)/2, flag success.
// Build option TEST_HARNESS_INJECT_ERR_EN (in harness_accum) forces the check to fail.
module test_harness
  import test_harness_pkg::*;
#(
  parameter int unsigned START_DELAY = 8,
  parameter int unsigned NUM_TERMS   = 100
) (
  input  logic clock,
  input  logic reset,
  output logic io_success
);

  localparam logic [ACC_W-1:0] Gold      = series_gold(NUM_TERMS);
  localparam logic [7:0]       DelayLoad = 8'(START_DELAY - 1);

  test_harness_if acc_if ();

  th_state_t  state_q, state_d;
  logic [7:0] dly_q, dly_d;
  logic       success_q, success_d;
  logic       clear;

  // The idle edge counts as the first delay cycle; RUN begins on the edge the counter hits zero.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        dly_d = DelayLoad;
        if (DelayLoad == 8'd0) begin
          clear   = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        dly_d = dly_q - 8'd1;
        if (dly_d == 8'd0) begin
          clear   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (acc_if.last) state_d = StCheck;
      end
      StCheck: begin
        state_d = (acc_if.acc == Gold) ? StPass : StFail;
      end
      default: begin
        state_d = state_q;
      end
    endcase
    success_d = (state_d == StPass);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      dly_q     <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      success_q <= success_d;
    end
  end

  assign acc_if.clear  = clear;
  assign acc_if.enable = (state_q == StRun);
  assign io_success    = success_q;

  harness_accum #(
    .NUM_TERMS (NUM_TERMS)
  ) u_accum (
    .clk_i   (clock),
    .rst_ni  (reset),
    .acc_bus (acc_if.slave)
  );

endmodule

// File: tb/tb_test_harness.sv
// Bench for test_harness: default, single-term and maximum-term builds against a timing/sum model.
module tb_test_harness;
  import test_harness_pkg::*;

  localparam int DefD = 8;
  localparam int DefN = 100;
  localparam int BigN = 65535;
`ifdef TEST_HARNESS_INJECT_ERR_EN
  localparam bit Inject = 1'b1;
`else
  localparam bit Inject = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_def = 1'b0, rst_big = 1'b0, rst_one = 1'b0;
  logic succ_def, succ_big, succ_one;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   big_done = 1'b0;

  always #5 clk = ~clk;

  test_harness u_def (
    .clock      (clk),
    .reset      (rst_def),
    .io_success (succ_def)
  );

  test_harness #(
    .START_DELAY (1),
    .NUM_TERMS   (BigN)
  ) u_big (
    .clock      (clk),
    .reset      (rst_big),
    .io_success (succ_big)
  );

  test_harness #(
    .START_DELAY (1),
    .NUM_TERMS   (1)
  ) u_one (
    .clock      (clk),
    .reset      (rst_one),
    .io_success (succ_one)
  );

  test_harness_if mon_if ();
  assign mon_if.clear  = u_def.acc_if.clear;
  assign mon_if.enable = u_def.acc_if.enable;
  assign mon_if.acc    = u_def.acc_if.acc;
  assign mon_if.last   = u_def.acc_if.last;

  typedef struct {
    int edge_n;
    bit exp_succ;
  } vec_t;
  vec_t vecs[6];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Success is visible from the (D+N+1)-th edge after release unless the error is injected.
  function automatic bit model_succ(input int k, input int d, input int n);
    return !Inject && (k >= d + n + 1);
  endfunction

  function automatic longint model_acc(input int n);
    longint s = 0;
    for (int i = 1; i <= n; i++) s += i;
    if (Inject) s += 1;
    return s;
  endfunction

  task automatic run_checked(input int edges, input string tag);
    rst_def = 1'b1;
    for (int k = 1; k <= edges; k++) begin
      @(negedge clk);
      check(tag, succ_def, model_succ(k, DefD, DefN));
    end
  endtask

  task automatic pulse_reset(input int hold, input string tag);
    #1 rst_def = 1'b0;
    #1;
    check({tag, "_async_succ"}, succ_def, 0);
    check({tag, "_async_acc"}, mon_if.acc, 0);
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_held"}, succ_def, 0);
    end
  endtask

  initial begin : big_run
    @(negedge clk);
    rst_big = 1'b1;
    for (int k = 1; k <= BigN + 2; k++) begin
      @(negedge clk);
      if (k == BigN + 1) check("big_acc", u_big.acc_if.acc, model_acc(BigN));
      if (k >= BigN) check("big_succ", succ_big, model_succ(k, 1, BigN));
    end
    big_done = 1'b1;
  end

  initial begin : main
    vecs[0] = '{1, 1'b0};
    vecs[1] = '{DefD, 1'b0};
    vecs[2] = '{DefD + DefN, 1'b0};
    vecs[3] = '{DefD + DefN + 1, 1'b1};
    vecs[4] = '{DefD + DefN + 2, 1'b1};
    vecs[5] = '{DefD + DefN + 1000, 1'b1};

    @(negedge clk);
    check("reset_succ", succ_def, 0);
    check("reset_acc", mon_if.acc, 0);
    check("reset_one_succ", succ_one, 0);
    rst_def = 1'b1;
    rst_one = 1'b1;

    for (int k = 1; k <= DefD + DefN + 1000; k++) begin
      @(negedge clk);
      check("def_cycle", succ_def, model_succ(k, DefD, DefN));
      foreach (vecs[i]) begin
        if (vecs[i].edge_n == k) check("def_vec", succ_def, vecs[i].exp_succ & !Inject);
      end
      if (k == DefD + DefN) check("def_acc", mon_if.acc, model_acc(DefN));
      if (k <= 5) check("one_succ", succ_one, model_succ(k, 1, 1));
      if (k == 2) check("one_acc", u_one.acc_if.acc, model_acc(1));
    end

    pulse_reset(2, "pass_rst");
    run_checked(50, "mid");
    pulse_reset(10, "mid_rst");
    run_checked(DefD + DefN + 6, "post_mid");

    repeat (6) begin
      pulse_reset(int'($urandom_range(1, 4)), "rnd_rst");
      run_checked(int'($urandom_range(1, 140)), "rnd");
    end
    pulse_reset(1, "final_rst");
    run_checked(DefD + DefN + 6, "final");

    for (int i = 0; i < 70000 && !big_done; i++) @(negedge clk);
    check("big_done", big_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
